vscpu_core: RTL and testbench



---
 rtl/vscpu_pkg.sv | 43 ++++
 rtl/vscpu_alu.sv | 29 ++
 rtl/vscpu_core.sv | 148 ++++++++++++++
 tb/tb_vscpu_core.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vscpu_pkg.sv
// Shared types for the vscpu core: opcode and state encodings plus the
// instruction-class helpers used by the decoder.
package vscpu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD      = 4'h0,
    OP_ADD_IMM  = 4'h1,
    OP_NAND     = 4'h2,
    OP_NAND_IMM = 4'h3,
    OP_SRL      = 4'h4,
    OP_SRL_IMM  = 4'h5,
    OP_LT       = 4'h6,
    OP_LT_IMM   = 4'h7,
    OP_CP       = 4'h8,
    OP_CP_IMM   = 4'h9,
    OP_CPI      = 4'hA,
    OP_CPI_IMM  = 4'hB,
    OP_BZJ      = 4'hC,
    OP_BZJ_IMM  = 4'hD,
    OP_MUL      = 4'hE,
    OP_MUL_IMM  = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_RD1,
    ST_RD2,
    ST_WB
  } state_t;

  function automatic logic is_alu_imm(opcode_t op);
    return op inside {OP_ADD_IMM, OP_NAND_IMM, OP_SRL_IMM, OP_LT_IMM, OP_MUL_IMM};
  endfunction

  // CP and CPI fetch their first operand through B; everything else through A.
  function automatic logic rd1_uses_b(opcode_t op);
    return op inside {OP_CP, OP_CPI};
  endfunction

endpackage

// File: rtl/vscpu_alu.sv
// Combinational datapath for the arithmetic/logic opcodes; register and
// immediate forms share one unit, the caller selects y.
module vscpu_alu
  import vscpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  opcode_t           op,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] result
);

  localparam logic [DATA_W-1:0] SHIFT_SPAN = DATA_W'(DATA_W);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD, OP_ADD_IMM:   result = x + y;
      OP_NAND, OP_NAND_IMM: result = ~(x & y);
      // Counts below the word width shift right; larger counts wrap into a left shift.
      OP_SRL, OP_SRL_IMM:   result = (y < SHIFT_SPAN) ? (x >> y) : (x << (y - SHIFT_SPAN));
      OP_LT, OP_LT_IMM:     result = {{(DATA_W-1){1'b0}}, (x < y)};
      OP_MUL, OP_MUL_IMM:   result = x * y;
      default:              result = y;
    endcase
  end

endmodule

// File: rtl/vscpu_core.sv
// Multi-cycle memory-to-memory CPU: one memory access per state, every access
// held on a req/ready handshake, instructions retired one at a time.
module vscpu_core
  import vscpu_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 14,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              retire
);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] iw, r1, r2;
  logic [DATA_W-1:0] b_ext, alu_y, alu_result, bzji_sum;
  logic [ADDR_W-1:0] a_fld, b_fld, pc_inc;
  opcode_t           op, fetch_op;
  logic              done;
  state_t            end_state;

  assign op        = opcode_t'(iw[DATA_W-1 -: OP_W]);
  assign fetch_op  = opcode_t'(mem_rdata[DATA_W-1 -: OP_W]);
  assign a_fld     = iw[2*ADDR_W-1:ADDR_W];
  assign b_fld     = iw[ADDR_W-1:0];
  assign b_ext     = {{(DATA_W-ADDR_W){1'b0}}, b_fld};
  assign pc_inc    = pc + ADDR_W'(1);
  assign bzji_sum  = mem_rdata + b_ext;
  assign done      = mem_req && mem_ready;
  assign end_state = run ? ST_FETCH : ST_IDLE;
  assign busy      = !(state == ST_IDLE && !run);
  assign alu_y     = is_alu_imm(op) ? b_ext : r2;

  vscpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .x      (r1),
    .y      (alu_y),
    .result (alu_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (run) state_nxt = ST_FETCH;
      ST_FETCH: if (done) state_nxt = (fetch_op == OP_CP_IMM) ? ST_WB : ST_RD1;
      ST_RD1: if (done) begin
        if (op == OP_BZJ_IMM)                  state_nxt = end_state;
        else if (is_alu_imm(op) || op == OP_CP) state_nxt = ST_WB;
        else                                   state_nxt = ST_RD2;
      end
      // Indirect copies have both operands after two reads, so they write next.
      ST_RD2:   if (done) state_nxt = (op == OP_BZJ) ? end_state : ST_WB;
      ST_WB:    if (done) state_nxt = end_state;
      default:  state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc;
    case (state)
      ST_FETCH: mem_req = 1'b1;
      ST_RD1: begin
        mem_req  = 1'b1;
        mem_addr = rd1_uses_b(op) ? b_fld : a_fld;
      end
      ST_RD2: begin
        mem_req  = 1'b1;
        mem_addr = (op == OP_CPI) ? r1[ADDR_W-1:0] : b_fld;
      end
      ST_WB: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = (op == OP_CPI_IMM) ? r1[ADDR_W-1:0] : a_fld;
      end
      default: ;
    endcase
    // Reset withdraws any access in flight without waiting for a clock.
    if (rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  always_comb begin
    case (op)
      OP_CP:              mem_wdata = r1;
      OP_CP_IMM:          mem_wdata = b_ext;
      OP_CPI, OP_CPI_IMM: mem_wdata = r2;
      default:            mem_wdata = alu_result;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      iw     <= '0;
      r1     <= '0;
      r2     <= '0;
      retire <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every register samples pre-edge values.
      retire <= 1'b0;
      if (done) begin
        case (state)
          ST_FETCH: iw <= mem_rdata;
          ST_RD1: begin
            r1 <= mem_rdata;
            if (op == OP_BZJ_IMM) begin
              pc     <= bzji_sum[ADDR_W-1:0];
              retire <= 1'b1;
            end
          end
          ST_RD2: begin
            r2 <= mem_rdata;
            if (op == OP_BZJ) begin
              pc     <= (mem_rdata == '0) ? r1[ADDR_W-1:0] : pc_inc;
              retire <= 1'b1;
            end
          end
          ST_WB: begin
            pc     <= pc_inc;
            retire <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vscpu_core.sv
// Bench for vscpu_core: a wait-state RAM responder plus an instruction-level
// reference model that predicts pc, the written word and the cycle count.
module tb_vscpu_core;

  localparam int DW = 32;
  localparam int AW = 14;
  localparam int MEM_WORDS = 2**AW;

  logic          clk = 1'b0;
  logic          rst, run, mem_req, mem_we, mem_ready, busy, retire;
  logic [AW-1:0] mem_addr, pc;
  logic [DW-1:0] mem_wdata, mem_rdata;

  vscpu_core #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC('0)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc        (pc),
    .busy      (busy),
    .retire    (retire)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram     [0:MEM_WORDS-1];
  logic [DW-1:0] ref_mem [0:MEM_WORDS-1];
  int            checks = 0, errors = 0, wr_cnt = 0, stall_cnt = 0, ready_mode = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_data = '0;

  // Cycles per instruction with zero wait states: fetch + reads + write.
  int cyc_tab [16] = '{4, 3, 4, 3, 4, 3, 4, 3, 3, 2, 4, 4, 3, 2, 4, 3};

  logic [AW-1:0] ref_pc, exp_pc, exp_addr;
  logic [DW-1:0] exp_data;
  bit            exp_wr;
  int            wr_base, exp_cycles;

  assign mem_rdata = ram[mem_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin : responder
    for (int i = 0; i < MEM_WORDS; i++) ram[i] = '0;
    forever begin
      @(posedge clk);
      if (host_we) ram[host_addr] = host_data;
      if (mem_req && mem_ready && mem_we) begin
        ram[mem_addr] = mem_wdata;
        wr_cnt++;
        last_wr_addr = mem_addr;
      end
    end
  end

  // Drives mem_ready and checks that a stalled access keeps its request stable.
  initial begin : ready_driver
    logic        stall_prev;
    logic [63:0] snap;
    stall_prev = 1'b0;
    snap = '0;
    mem_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_prev && !rst)
        check("hold_stable", {16'b0, mem_req, mem_we, mem_addr, mem_wdata}, snap);
      case (ready_mode)
        0: mem_ready = 1'b1;
        1: mem_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (mem_req && mem_we && stall_cnt < 3) begin
            mem_ready = 1'b0;
            stall_cnt++;
          end else begin
            mem_ready = 1'b1;
          end
        end
      endcase
      stall_prev = mem_req && !mem_ready && !rst;
      snap = {16'b0, mem_req, mem_we, mem_addr, mem_wdata};
    end
  end

  task automatic set_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    host_addr = a;
    host_data = d;
    host_we   = 1'b1;
    @(posedge clk);
    #1 host_we = 1'b0;
    ref_mem[a] = d;
  endtask

  function automatic logic [DW-1:0] shift_rule(input logic [DW-1:0] v, input logic [DW-1:0] s);
    if (s < 32) return v >> s;
    if (s - 32 >= 32) return '0;
    return v << (s - 32);
  endfunction

  // Places the instruction at the model pc and predicts its architectural effect.
  task automatic prepare(input logic [3:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [DW-1:0] ma, mb, bi, sum;
    logic [63:0]   prod;
    set_word(ref_pc, {op, a, b});
    ma = ref_mem[a];
    mb = ref_mem[b];
    bi = {{(DW-AW){1'b0}}, b};
    exp_wr   = 1'b1;
    exp_addr = a;
    exp_pc   = ref_pc + 1'b1;
    exp_data = '0;
    case (op)
      4'd0:  exp_data = ma + mb;
      4'd1:  exp_data = ma + bi;
      4'd2:  exp_data = ~(ma & mb);
      4'd3:  exp_data = ~(ma & bi);
      4'd4:  exp_data = shift_rule(ma, mb);
      4'd5:  exp_data = shift_rule(ma, bi);
      4'd6:  exp_data = (ma < mb) ? 32'd1 : 32'd0;
      4'd7:  exp_data = (ma < bi) ? 32'd1 : 32'd0;
      4'd8:  exp_data = mb;
      4'd9:  exp_data = bi;
      4'd10: exp_data = ref_mem[mb[AW-1:0]];
      4'd11: begin exp_addr = ma[AW-1:0]; exp_data = mb; end
      4'd12: begin exp_wr = 1'b0; exp_pc = (mb == 0) ? ma[AW-1:0] : ref_pc + 1'b1; end
      4'd13: begin exp_wr = 1'b0; sum = ma + bi; exp_pc = sum[AW-1:0]; end
      4'd14: begin prod = {32'b0, ma} * {32'b0, mb}; exp_data = prod[31:0]; end
      default: begin prod = {32'b0, ma} * {32'b0, bi}; exp_data = prod[31:0]; end
    endcase
    exp_cycles = cyc_tab[op];
    wr_base = wr_cnt;
  endtask

  task automatic start_step(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    run = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 50);
    run = 1'b0;
    check({tag, "_start"}, mem_req, 1);
  endtask

  // Entered at a negedge where the instruction's first access is already requested.
  task automatic complete_step(input string tag, input bit timed);
    int cyc, n;
    cyc = 1;
    n = 0;
    while (!retire && n < 200) begin
      @(negedge clk);
      n++;
      if (!retire && mem_req) cyc++;
    end
    check({tag, "_retire"}, retire, 1);
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_writes"}, wr_cnt - wr_base, exp_wr);
    if (exp_wr) begin
      check({tag, "_waddr"}, last_wr_addr, exp_addr);
      check({tag, "_wdata"}, ram[exp_addr], exp_data);
      ref_mem[exp_addr] = exp_data;
    end
    if (timed && ready_mode == 0) check({tag, "_cycles"}, cyc, exp_cycles);
    ref_pc = exp_pc;
    @(negedge clk);
    check({tag, "_pulse"}, retire, 0);
    @(negedge clk);
    check({tag, "_idle"}, {busy, mem_req}, 0);
  endtask

  function automatic logic [DW-1:0] rand_val();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return $urandom_range(0, 70);
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic random_instr(input logic [3:0] op, input string tag, input bit timed);
    logic [AW-1:0] a, b;
    do a = AW'($urandom); while (a == ref_pc);
    do b = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 40)) : AW'($urandom);
    while (b == ref_pc);
    set_word(a, rand_val());
    if (b != a) set_word(b, (op == 4'd12 && $urandom_range(0, 1) != 0) ? '0 : rand_val());
    prepare(op, a, b);
    start_step(tag);
    complete_step(tag, timed);
  endtask

  initial begin : main
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = '0;
    rst = 1'b1;
    run = 1'b0;
    ref_pc = '0;
    repeat (2) @(negedge clk);
    check("reset_req", mem_req, 0);
    check("reset_we", mem_we, 0);
    check("reset_retire", retire, 0);
    check("reset_busy", busy, 1);
    check("reset_pc", pc, 0);

    // Out of reset the core fetches mem[0] even with run low.
    set_word(10, 5);
    set_word(11, 7);
    prepare(4'd0, 10, 11);
    @(negedge clk);
    rst = 1'b0;
    complete_step("add", 1'b1);
    check("add_sum", ram[10], 12);
    check("add_pc", pc, 1);

    set_word(60, 32'h8000_0000);
    prepare(4'd5, 60, 4);
    start_step("srli4");
    complete_step("srli4", 1'b1);
    check("srli4_val", ram[60], 32'h0800_0000);
    set_word(60, 32'h8000_0000);
    prepare(4'd5, 60, 33);
    start_step("srli33");
    complete_step("srli33", 1'b1);
    check("srli33_val", ram[60], 0);
    set_word(61, 1);
    prepare(4'd5, 61, 35);
    start_step("srli35");
    complete_step("srli35", 1'b1);
    check("srli35_val", ram[61], 8);

    stall_cnt = 0;
    ready_mode = 2;
    prepare(4'd9, 20, 14'h3FFF);
    start_step("cpi_stall");
    complete_step("cpi_stall", 1'b0);
    check("cpi_stall_val", ram[20], 32'h3FFF);
    check("cpi_stall_waits", stall_cnt, 3);
    ready_mode = 0;

    set_word(40, 50);
    set_word(41, 32'hDEAD);
    prepare(4'd11, 40, 41);
    start_step("cpii");
    complete_step("cpii", 1'b1);
    check("cpii_val", ram[50], 32'hDEAD);

    set_word(30, 100);
    set_word(31, 0);
    prepare(4'd12, 30, 31);
    start_step("bzj_taken");
    complete_step("bzj_taken", 1'b1);
    check("bzj_taken_pc", pc, 100);
    set_word(31, 1);
    prepare(4'd12, 30, 31);
    start_step("bzj_fall");
    complete_step("bzj_fall", 1'b1);
    check("bzj_fall_pc", pc, 101);

    // Reset during the second operand read of a MUL.
    set_word(80, 3);
    set_word(81, 5);
    prepare(4'd14, 80, 81);
    start_step("mul_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_req_drop", mem_req, 0);
    check("rst_pc", pc, 0);
    check("rst_retire", retire, 0);
    repeat (2) @(negedge clk);
    check("rst_no_write", wr_cnt - wr_base, 0);
    check("rst_mem_kept", ram[80], 3);
    ref_pc = '0;
    set_word(70, 9);
    prepare(4'd1, 70, 3);
    @(negedge clk);
    rst = 1'b0;
    complete_step("post_rst", 1'b1);
    check("post_rst_val", ram[70], 12);

    for (int op = 0; op < 16; op++)
      random_instr(4'(op), $sformatf("timed_op%0d", op), 1'b1);

    ready_mode = 1;
    for (int k = 0; k < 150; k++) begin
      logic [3:0] rop;
      rop = 4'($urandom_range(0, 15));
      random_instr(rop, $sformatf("rand%0d_op%0d", k, rop), 1'b0);
    end
    ready_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
